// File: rtl/cntr_pkg.sv
// Shared counter/arbiter definitions: FSM state encoding and a reusable
// round-robin "first set bit after pointer" search.
package cntr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int RR_MAX = 16;

  // First set bit of req[n-1:0] searching upward from ptr+1, wrapping to 0.
  // Returns 0 when nothing is set; callers qualify with |req.
  function automatic logic [3:0] rr_first(input logic [RR_MAX-1:0] req,
                                          input logic [3:0]        ptr,
                                          input int                n);
    logic [3:0] pick;
    logic       found;
    int         j;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= RR_MAX; k++) begin
      j = (int'(ptr) + k) % n;
      if (k <= n && !found && req[j[3:0]]) begin
        pick  = 4'(j);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/cntr_updn.sv
// Loadable up/down counter with synchronous clear/load and async reset.
module cntr_updn #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             sclear,
  input  logic             sload,
  input  logic [WIDTH-1:0] sdata,
  input  logic             inc_not_dec,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               q <= '0;
    else if (ena) begin
      if (sclear)          q <= '0;
      else if (sload)      q <= sdata;
      else if (inc_not_dec) q <= q + 1'b1;
      else                 q <= q - 1'b1;
    end
  end

endmodule

// File: rtl/cntr_timer_arb.sv
// Round-robin sequencer time-sharing one cntr_updn among NREQ requesters;
// each grant loads the requester's length and counts it down to zero.
module cntr_timer_arb
  import cntr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] len,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [WIDTH-1:0]      q
);

  localparam int IW = $clog2(NREQ);

  state_e          state, state_nxt;
  logic [IW-1:0]   cur;      // current grantee, doubles as the round-robin pointer
  logic [IW-1:0]   pick;
  logic [WIDTH-1:0] len_q;
  logic [NREQ-1:0] cur_oh;
  logic            abort;
  logic            ena, sclear, sload, inc_not_dec;

  assign pick   = IW'(rr_first(RR_MAX'(req), 4'(cur), NREQ));
  assign cur_oh = NREQ'(1) << cur;
  assign abort  = !req[cur] && (state == LOAD || state == RUN);

  assign busy = (state != IDLE);
  assign gnt  = busy ? cur_oh : '0;
  assign done = (state == DONE) ? cur_oh : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Reset pointer to the last index so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur   <= IW'(NREQ - 1);
      len_q <= '0;
    end else if (state == IDLE && |req) begin
      cur   <= pick;
      len_q <= len[pick*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (|req) state_nxt = LOAD;
      LOAD: state_nxt = abort ? IDLE : RUN;
      RUN:  if (abort)        state_nxt = IDLE;
            else if (q == '0) state_nxt = DONE;
      DONE: state_nxt = IDLE;
    endcase
  end

  // Abort clears the counter so q reads 0 once back in IDLE.
  always_comb begin
    ena         = 1'b0;
    sclear      = 1'b0;
    sload       = 1'b0;
    inc_not_dec = 1'b0;
    unique case (state)
      LOAD: begin
        ena    = 1'b1;
        sclear = abort;
        sload  = !abort;
      end
      RUN: begin
        ena    = abort || (q != '0);
        sclear = abort;
      end
      default: ;
    endcase
  end

  cntr_updn #(.WIDTH(WIDTH)) u_cntr (
    .clk         (clk),
    .rst         (~rst_n),
    .ena         (ena),
    .sclear      (sclear),
    .sload       (sload),
    .sdata       (len_q),
    .inc_not_dec (inc_not_dec),
    .q           (q)
  );

endmodule
